// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned ADD3_THRESHOLD = 5;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/ready/done handshake plus operand and result between a producer and the converter.
interface bin_to_bcd_seq_if #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
);
  import bin_to_bcd_seq_pkg::*;

  logic                      start;
  logic [BIN_W-1:0]          bin_in;
  logic                      ready;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W*DIGITS-1:0] bcd_out;

  modport master (
    output start, bin_in,
    input  ready, busy, done, bcd_out
  );

  modport slave (
    input  start, bin_in,
    output ready, busy, done, bcd_out
  );
endinterface

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more, wrapping within 4 bits.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);
  always_comb begin
    adj = digit;
    if (digit >= DIGIT_W'(ADD3_THRESHOLD)) adj = digit + DIGIT_W'(3);
  end
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_digits_check
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] scratch_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] scratch_shift;
  logic [CNT_W-1:0] cnt_q;
  logic             last;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch_q[i*DIGIT_W +: DIGIT_W]),
      .adj   (adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  assign scratch_shift = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign last          = (cnt_q == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CONVERT;
      CONVERT: if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Result is loaded on the edge entering DONE (scratch is frozen in DONE),
  // so bcd_out is already valid during the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            bin_q     <= bus.bin_in;
            scratch_q <= '0;
            cnt_q     <= '0;
          end
        end
        CONVERT: begin
          scratch_q <= scratch_shift;
          bin_q     <= bin_q << 1;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (last) bcd_q <= scratch_shift;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q == CONVERT) || (state_q == DONE);
  assign bus.done    = (state_q == DONE);
  assign bus.bcd_out = bcd_q;

endmodule
